axis_fifo_downsizer: RTL

Wide-to-narrow AXI-Stream buffer. It is the transmit-side counterpart of the narrow-to-wide packing FIFO. Wide words are accepted into a FWFT FIFO (simple_fifo). A serializer then emits them as DATA_IN_WIDTH/DATA_OUT_WIDTH narrow beats, lowest lane first, preserving tlast and tkeep. It sits between a wide datapath (e.g. DMA/memory side) and a narrow stream interface.

---
 rtl/axis_fifo_downsizer_pkg.sv | 11 +
 rtl/axis_word_splitter.sv | 100 ++++++++++
 rtl/simple_fifo.sv | 54 +++++
 rtl/axis_fifo_downsizer.sv | 70 +++++++
 4 files changed

// File: rtl/axis_fifo_downsizer_pkg.sv
// Shared constants and serializer state encoding for the wide-to-narrow AXI-Stream buffer.
package axis_fifo_downsizer_pkg;
  localparam int DEF_DATA_IN_WIDTH  = 128;
  localparam int DEF_DATA_OUT_WIDTH = 16;
  localparam int RATIO      = DEF_DATA_IN_WIDTH / DEF_DATA_OUT_WIDTH;
  localparam int IDX_W      = $clog2(RATIO);
  localparam int KEEP_IN_W  = DEF_DATA_IN_WIDTH / 8;
  localparam int KEEP_OUT_W = DEF_DATA_OUT_WIDTH / 8;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;
endpackage

// File: rtl/axis_word_splitter.sv
// Serializes one wide word into narrow beats, lowest lane first, from output flops.
// AXIS_FIFO_DOWNSIZER_TRIM_EN: trailing zero-keep lanes of a tlast word are not emitted.
module axis_word_splitter
  import axis_fifo_downsizer_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_IN_WIDTH-1:0]    i_word_data,
  input  logic [DATA_IN_WIDTH/8-1:0]  i_word_keep,
  input  logic                        i_word_last,
  input  logic                        i_rd_empty,
  output logic                        o_rd_ena,
  output logic [DATA_OUT_WIDTH-1:0]   o_tdata,
  output logic [DATA_OUT_WIDTH/8-1:0] o_tkeep,
  output logic                        o_tlast,
  output logic                        o_tvalid,
  input  logic                        i_tready
);
  localparam int L_RATIO = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int L_IDX_W = $clog2(L_RATIO);
  localparam int L_KI    = DATA_IN_WIDTH / 8;
  localparam int L_KO    = DATA_OUT_WIDTH / 8;

  ser_state_t                r_state, w_state_nxt;
  logic [DATA_IN_WIDTH-1:0]  r_data;
  logic [L_KI-1:0]           r_keep;
  logic                      r_word_last, r_tlast;
  logic [L_IDX_W-1:0]        r_idx, r_last_idx, w_idx_inc, w_lane_last;
  logic                      w_hs, w_word_end;

  assign w_hs       = (r_state == SHIFT) & i_tready;
  assign w_word_end = w_hs & (r_idx == r_last_idx);
  assign w_idx_inc  = r_idx + L_IDX_W'(1);

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;

  // Refill on the final beat of a word so back-to-back words have no bubble.
  always_comb begin
    w_state_nxt = r_state;
    o_rd_ena    = 1'b0;
    case (r_state)
      IDLE:
        if (!i_rd_empty) begin
          o_rd_ena    = 1'b1;
          w_state_nxt = SHIFT;
        end
      SHIFT:
        if (w_word_end) begin
          if (!i_rd_empty) o_rd_ena = 1'b1;
          else             w_state_nxt = IDLE;
        end
    endcase
  end

  always_comb begin
    w_lane_last = L_IDX_W'(L_RATIO - 1);
`ifdef AXIS_FIFO_DOWNSIZER_TRIM_EN
    if (i_word_last) begin
      w_lane_last = '0;
      for (int l = 0; l < L_RATIO; l++)
        if (|i_word_keep[l*L_KO +: L_KO]) w_lane_last = L_IDX_W'(l);
    end
`endif
  end

  // The word is shifted down so the current lane always sits in the low bits.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_data      <= '0;
      r_keep      <= '0;
      r_word_last <= 1'b0;
      r_tlast     <= 1'b0;
      r_idx       <= '0;
      r_last_idx  <= '0;
    end else if (o_rd_ena) begin
      r_data      <= i_word_data;
      r_keep      <= i_word_keep;
      r_word_last <= i_word_last;
      r_idx       <= '0;
      r_last_idx  <= w_lane_last;
      r_tlast     <= i_word_last & (w_lane_last == '0);
    end else if (w_word_end) begin
      r_tlast <= 1'b0;
    end else if (w_hs) begin
      r_data  <= r_data >> DATA_OUT_WIDTH;
      r_keep  <= r_keep >> L_KO;
      r_idx   <= w_idx_inc;
      r_tlast <= r_word_last & (w_idx_inc == r_last_idx);
    end

  assign o_tdata  = r_data[DATA_OUT_WIDTH-1:0];
  assign o_tkeep  = r_keep[L_KO-1:0];
  assign o_tlast  = r_tlast;
  assign o_tvalid = (r_state == SHIFT);
endmodule

// File: rtl/simple_fifo.sv
// FWFT FIFO: RAM plus a prefetch output register; o_count includes the prefetched word.
module simple_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_ena,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_ena,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_empty,
  output logic [ADDR_WIDTH:0]   o_count
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  w_full, w_wr, w_rd, w_ram_empty, w_fetch;

  // Writes against a full FIFO are silently dropped.
  assign w_full      = (r_count == (ADDR_WIDTH+1)'(DEPTH));
  assign w_wr        = i_wr_ena & ~w_full;
  assign w_rd        = i_rd_ena & r_out_vld;
  assign w_ram_empty = (r_count == {{ADDR_WIDTH{1'b0}}, r_out_vld});
  assign w_fetch     = ~w_ram_empty & (~r_out_vld | w_rd);

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fetch) begin
        r_out_data <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      r_out_vld <= w_fetch | (r_out_vld & ~w_rd);
      r_count   <= r_count + (ADDR_WIDTH+1)'(w_wr) - (ADDR_WIDTH+1)'(w_rd);
    end

  assign o_rd_data  = r_out_data;
  assign o_rd_empty = ~r_out_vld;
  assign o_count    = r_count;
endmodule

// File: rtl/axis_fifo_downsizer.sv
// Wide-to-narrow AXI-Stream buffer: FWFT FIFO of wide words feeding a lane serializer.
// AXIS_FIFO_DOWNSIZER_TRIM_EN enables trimming of trailing zero-keep lanes on tlast words.
module axis_fifo_downsizer
  import axis_fifo_downsizer_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
  parameter int ADDR_WIDTH     = 8,
  parameter int FULL_SLACK     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_IN_WIDTH-1:0]    s_axis_tdata,
  input  logic [DATA_IN_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [DATA_OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [ADDR_WIDTH:0]         fifo_cnt
);
  localparam int L_KI    = DATA_IN_WIDTH / 8;
  localparam int L_FW    = DATA_IN_WIDTH + L_KI + 1;
  localparam int L_DEPTH = 2 ** ADDR_WIDTH;

  logic [L_FW-1:0]       w_rd_word;
  logic                  w_rd_empty, w_rd_ena, w_push, w_pop;
  logic                  r_s_ready;
  logic [ADDR_WIDTH+1:0] w_cnt_nxt;

  assign w_push    = s_axis_tvalid & r_s_ready;
  assign w_pop     = w_rd_ena & ~w_rd_empty;
  assign w_cnt_nxt = {1'b0, fifo_cnt} + (ADDR_WIDTH+2)'(w_push) - (ADDR_WIDTH+2)'(w_pop);

  // Ready is registered from the next-cycle count so it tracks fifo_cnt exactly.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_s_ready <= 1'b0;
    else     r_s_ready <= (w_cnt_nxt < (ADDR_WIDTH+2)'(L_DEPTH - FULL_SLACK));

  assign s_axis_tready = r_s_ready;

  simple_fifo #(.DATA_WIDTH(L_FW), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_ena  (w_push),
    .i_wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .i_rd_ena  (w_rd_ena),
    .o_rd_data (w_rd_word),
    .o_rd_empty(w_rd_empty),
    .o_count   (fifo_cnt)
  );

  axis_word_splitter #(.DATA_IN_WIDTH(DATA_IN_WIDTH), .DATA_OUT_WIDTH(DATA_OUT_WIDTH)) u_split (
    .clk        (clk),
    .rst        (rst),
    .i_word_data(w_rd_word[DATA_IN_WIDTH-1:0]),
    .i_word_keep(w_rd_word[DATA_IN_WIDTH +: L_KI]),
    .i_word_last(w_rd_word[L_FW-1]),
    .i_rd_empty (w_rd_empty),
    .o_rd_ena   (w_rd_ena),
    .o_tdata    (m_axis_tdata),
    .o_tkeep    (m_axis_tkeep),
    .o_tlast    (m_axis_tlast),
    .o_tvalid   (m_axis_tvalid),
    .i_tready   (m_axis_tready)
  );
endmodule
